ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage. Consumes operands from the ID/EX outputs.

---
 rtl/ex_muldiv_unit_pkg.sv | 13 +
 rtl/ex_muldiv_unit_md_abs.sv | 10 +
 rtl/ex_muldiv_unit.sv | 137 +++++++++++++
 tb/tb_ex_muldiv_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: op codes, FSM states and default width shared by the mul/div unit
package ex_muldiv_unit_pkg;
  localparam int MD_DATA_WIDTH = 32;
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;
endpackage

// File: rtl/ex_muldiv_unit_md_abs.sv
// md_abs: conditional two's-complement negation, used for operand magnitudes and result sign fix
module md_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);
  assign res_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative shift-add multiplier / restoring divider holding architectural HI/LO
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_regA,
  input  logic [DATA_WIDTH-1:0] i_regB,
  input  logic                  i_flush,
  input  logic                  i_wr_hi,
  input  logic                  i_wr_lo,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_div_by_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  md_state_e      state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic           div_q, div_d, sa_q, sa_d, sb_q, sb_d;
  logic           done_q, done_d, dbz_q, dbz_d;
  logic           in_signed, in_b_zero, in_neg_a, in_neg_b;
  logic [W-1:0]   mag_a, mag_b, fix_quo, fix_rem, div_sub;
  logic [2*W-1:0] fix_prod, mul_step, div_step;
  logic [W:0]     mul_sum, div_rem;
  logic           div_ge;
  // A zero divisor keeps the dividend raw so the remainder comes out as the unsigned dividend
  assign in_signed = ~i_op[0];
  assign in_b_zero = i_regB == '0;
  assign in_neg_a  = in_signed & i_regA[W-1] & ~in_b_zero;
  assign in_neg_b  = in_signed & i_regB[W-1];
  md_abs #(.W(W)) u_abs_a (.val_i(i_regA), .neg_i(in_neg_a), .res_o(mag_a));
  md_abs #(.W(W)) u_abs_b (.val_i(i_regB), .neg_i(in_neg_b), .res_o(mag_b));
  // Multiply keeps {partial_hi, multiplier_remaining}; each step adds then shifts right
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_step = {mul_sum, acc_q[W-1:1]};
  // Divide keeps {remainder, dividend/quotient}; each step shifts left and trial-subtracts
  assign div_rem  = acc_q[2*W-1:W-1];
  assign div_ge   = div_rem >= {1'b0, b_q};
  assign div_sub  = div_rem[W-1:0] - b_q;
  assign div_step = div_ge ? {div_sub, acc_q[W-2:0], 1'b1} : {div_rem[W-1:0], acc_q[W-2:0], 1'b0};
  md_abs #(.W(2*W)) u_fix_prod (.val_i(acc_q), .neg_i(sa_q ^ sb_q), .res_o(fix_prod));
  md_abs #(.W(W))   u_fix_quo  (.val_i(acc_q[W-1:0]), .neg_i(sa_q ^ sb_q), .res_o(fix_quo));
  md_abs #(.W(W))   u_fix_rem  (.val_i(acc_q[2*W-1:W]), .neg_i(sa_q), .res_o(fix_rem));
  // Next-state: flush wins everywhere, IDLE handles start and MTHI/MTLO, BUSY iterates, FIX commits
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    if (i_flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (i_valid) begin
            state_d = MD_BUSY;
            count_d = '0;
            acc_d   = {{W{1'b0}}, i_op[1] ? mag_a : mag_b};
            a_d     = mag_a;
            b_d     = mag_b;
            div_d   = i_op[1];
            sa_d    = in_neg_a;
            sb_d    = in_neg_b;
          end else begin
            hi_d = i_wr_hi ? i_wdata : hi_q;
            lo_d = i_wr_lo ? i_wdata : lo_q;
          end
        end
        MD_BUSY: begin
          acc_d   = div_q ? div_step : mul_step;
          count_d = count_q + CW'(1);
          state_d = (count_q == CW'(W - 1)) ? MD_FIX : MD_BUSY;
        end
        MD_FIX: begin
          state_d      = MD_IDLE;
          {hi_d, lo_d} = div_q ? {fix_rem, fix_quo} : fix_prod;
          done_d       = 1'b1;
          dbz_d        = div_q & (b_q == '0);
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end
  assign o_hi          = hi_q;
  assign o_lo          = lo_q;
  assign o_busy        = state_q != MD_IDLE;
  assign o_done        = done_q;
  assign o_div_by_zero = dbz_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors for the iterative mul/div unit
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] ra = '0, rb = '0, wdata = '0;
  logic        flush = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, dbz;
  int          n_cmp = 0;
  int          n_err = 0;

  ex_muldiv_unit dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_op(op),
    .i_regA(ra), .i_regB(rb), .i_flush(flush), .i_wr_hi(wr_hi), .i_wr_lo(wr_lo),
    .i_wdata(wdata), .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done),
    .o_div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input logic poke, input logic wlo);
    int busy_n = 0;
    int done_n = 0;
    logic dbz_at = 1'b0;
    logic busy_at = 1'b1;
    logic [31:0] lo_before = lo;
    @(negedge clk);
    valid = 1'b1; op = o; ra = a; rb = b;
    wr_lo = wlo; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 valid = 1'b0; wr_lo = 1'b0;
    if (wlo) chk({tag, "_lo_write_dropped"}, lo, lo_before);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        dbz_at = dbz;
        busy_at = busy;
      end
      valid = poke && (i == 5);
    end
    valid = 1'b0;
    chk({tag, "_busy_cycles"}, busy_n, 33);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_busy_at_done"}, busy_at, 1'b0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dbz"}, dbz_at, edbz);
  endtask

  task automatic write_hilo(input logic h, input logic [31:0] d);
    @(negedge clk);
    wr_hi = h; wr_lo = ~h; wdata = d;
    @(posedge clk);
    #1 wr_hi = 1'b0; wr_lo = 1'b0;
  endtask

  initial begin
    int done_n;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    rst_n = 1'b1;
    do_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    do_op("mult_m1_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0);
    do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    do_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    do_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    do_op("divu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op("divu_9_2", 2'b11, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0, 1'b0, 1'b0);
    do_op("div_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    write_hilo(1'b1, 32'h1234);
    chk("mthi", hi, 32'h1234);
    write_hilo(1'b0, 32'h5678);
    chk("mtlo", lo, 32'h5678);
    chk("mtlo_hi_kept", hi, 32'h1234);
    do_op("multu_wlo", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0, 1'b1);
    do_op("divu_poke", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, 1'b0);
    write_hilo(1'b1, 32'hAAAA);
    @(negedge clk);
    valid = 1'b1; op = 2'b10; ra = 32'd100; rb = 32'd7;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy_after", busy, 1'b0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("flush_no_done", done_n, 0);
    chk("flush_hi_kept", hi, 32'hAAAA);
    chk("flush_lo_kept", lo, 32'd14);
    @(negedge clk);
    valid = 1'b1; op = 2'b10; ra = 32'd100; rb = 32'd7;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
